// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM state type and write-mask helper for the LSU.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   // Lanes shifted past byte 3 fall off the 4-bit mask.
   function automatic logic [3:0] wmask_for(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         SZ_B:    m = 4'b0001 << off;
         SZ_H:    m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core request/response and physical memory port signals of lsu_mem_master.
interface lsu_mem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_sext;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_valid;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic        mem_wen;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;

   modport master (
      input  req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
             resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
   );

   modport slave (
      output req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
             resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load alignment: lane shift by byte offset, then sign/zero extension.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        sext,
   output logic [31:0] data
);

   logic [31:0] lane;

   always_comb begin
      lane = rdata >> {off, 3'b000};
      case (size)
         SZ_B:    data = {{24{sext & lane[7]}}, lane[7:0]};
         SZ_H:    data = {{16{sext & lane[15]}}, lane[15:0]};
         default: data = lane;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit driving a single-cycle PMEM-style port; one response per request.
// Define LSU_ALIGN_CHECK_EN to reject misaligned and reserved-size accesses with resp_err.
module lsu_mem_master
   import lsu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   lsu_mem_master_if.master bus
);

   state_e      state_q, state_d;
   logic        wen_q, wen_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        req_err;
   logic [31:0] load_data;

`ifdef LSU_ALIGN_CHECK_EN
   assign req_err = (bus.req_size == 2'd3) ||
                    (bus.req_size == SZ_H && bus.req_addr[0]) ||
                    (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'd0);
`else
   assign req_err = 1'b0;
`endif

   lsu_load_align u_align (
      .rdata (bus.mem_rdata),
      .off   (addr_q[1:0]),
      .size  (size_q),
      .sext  (sext_q),
      .data  (load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= SZ_B;
         sext_q  <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      wen_d          = wen_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      size_d         = size_q;
      sext_d         = sext_q;
      rdata_d        = rdata_q;
      err_d          = err_q;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_valid  = 1'b0;
      bus.mem_wen    = 1'b0;
      bus.mem_raddr  = '0;
      bus.mem_waddr  = '0;
      bus.mem_wdata  = '0;
      bus.mem_wmask  = '0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               wen_d   = bus.req_wen;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               size_d  = bus.req_size;
               sext_d  = bus.req_sext;
               rdata_d = '0;
               err_d   = req_err;
               state_d = req_err ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            bus.mem_valid = 1'b1;
            bus.mem_raddr = {addr_q[31:2], 2'b00};
            bus.mem_waddr = {addr_q[31:2], 2'b00};
            bus.mem_wen   = wen_q;
            // Write lanes are only driven for stores so loads present a clean bus.
            if (wen_q) begin
               bus.mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
               bus.mem_wmask = {4'b0000, wmask_for(size_q, addr_q[1:0])};
            end
            state_d = WAIT;
         end
         WAIT: begin
            rdata_d = wen_q ? '0 : load_data;
            state_d = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed requests, monitor-side checking of memory and response ports.
module tb_lsu_mem_master;
   import lsu_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  wmask;
   } memx_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] mem_word = '0;
   int n_checks = 0;
   int n_fail = 0;
   resp_t resp_q[$];
   memx_t mem_q[$];

   lsu_mem_master_if bus();

   lsu_mem_master dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model: read data valid the cycle after the strobe, zero otherwise.
   always @(posedge clk or posedge rst) begin
      if (rst) bus.mem_rdata <= '0;
      else     bus.mem_rdata <= (bus.mem_valid && !bus.mem_wen) ? mem_word : 32'h0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_valid) begin
            if (mem_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_mem_valid: got addr %h expected no memory access", bus.mem_raddr);
            end else begin
               memx_t e;
               e = mem_q.pop_front();
               chk("mem_wen", {31'b0, bus.mem_wen}, {31'b0, e.wen});
               chk("mem_raddr", bus.mem_raddr, e.addr);
               chk("mem_waddr", bus.mem_waddr, e.addr);
               chk("mem_wdata", bus.mem_wdata, e.wdata);
               chk("mem_wmask", {24'b0, bus.mem_wmask}, {24'b0, e.wmask});
            end
         end
         if (bus.resp_valid && bus.resp_ready) begin
            if (resp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: got rdata %h expected no response", bus.resp_rdata);
            end else begin
               resp_t r;
               r = resp_q.pop_front();
               chk("resp_rdata", bus.resp_rdata, r.rdata);
               chk("resp_err", {31'b0, bus.resp_err}, {31'b0, r.err});
            end
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
      chk({tag, "_resp_valid"}, {31'b0, bus.resp_valid}, 32'd0);
      chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
      chk({tag, "_resp_err"}, {31'b0, bus.resp_err}, 32'd0);
      chk({tag, "_mem_valid"}, {31'b0, bus.mem_valid}, 32'd0);
      chk({tag, "_mem_wen"}, {31'b0, bus.mem_wen}, 32'd0);
      chk({tag, "_mem_raddr"}, bus.mem_raddr, 32'd0);
      chk({tag, "_mem_waddr"}, bus.mem_waddr, 32'd0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
      chk({tag, "_mem_wmask"}, {24'b0, bus.mem_wmask}, 32'd0);
   endtask

   // Present one request, wait for acceptance, and optionally measure accept-to-resp_valid latency.
   task automatic send(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic sext, input int exp_lat);
      bit accepted;
      bit seen;
      int lat;
      accepted = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_wen   = wen;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_size  = size;
      bus.req_sext  = sext;
      for (int i = 0; i < 20; i++) begin
         if (bus.req_ready) begin
            accepted = 1;
            break;
         end
         @(negedge clk);
      end
      if (!accepted) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got req_ready 0 expected 1 within 20 cycles");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      if (exp_lat == 0) return;
      seen = 0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) chk("busy_req_ready", {31'b0, bus.req_ready}, 32'd0);
         if (bus.resp_valid) begin
            seen = 1;
            lat = i;
            break;
         end
      end
      if (!seen) lat = -1;
      chk("resp_latency", lat, exp_lat);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.req_ready && resp_q.size() == 0 && mem_q.size() == 0) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got pending resp %0d mem %0d expected 0 0", tag, resp_q.size(), mem_q.size());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_wen    = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_size   = SZ_B;
      bus.req_sext   = 1'b0;
      bus.resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset");

      // Word store
      mem_q.push_back('{wen: 1'b1, addr: 32'h8000_0004, wdata: 32'hDEAD_BEEF, wmask: 8'h0F});
      resp_q.push_back('{rdata: 32'h0, err: 1'b0});
      send(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, SZ_W, 1'b0, 3);
      wait_done("word_store");

      // Signed and unsigned byte load from lane 3
      mem_word = 32'h80FF_0102;
      mem_q.push_back('{wen: 1'b0, addr: 32'h8000_0000, wdata: 32'h0, wmask: 8'h00});
      resp_q.push_back('{rdata: 32'hFFFF_FF80, err: 1'b0});
      send(1'b0, 32'h8000_0003, 32'h0, SZ_B, 1'b1, 3);
      wait_done("byte_load_s");
      mem_q.push_back('{wen: 1'b0, addr: 32'h8000_0000, wdata: 32'h0, wmask: 8'h00});
      resp_q.push_back('{rdata: 32'h0000_0080, err: 1'b0});
      send(1'b0, 32'h8000_0003, 32'h0, SZ_B, 1'b0, 3);
      wait_done("byte_load_u");

      // Signed half load from upper half
      mem_q.push_back('{wen: 1'b0, addr: 32'h8000_0000, wdata: 32'h0, wmask: 8'h00});
      resp_q.push_back('{rdata: 32'hFFFF_80FF, err: 1'b0});
      send(1'b0, 32'h8000_0002, 32'h0, SZ_H, 1'b1, 3);
      wait_done("half_load_s");

      // Half store and byte store
      mem_q.push_back('{wen: 1'b1, addr: 32'h8000_0000, wdata: 32'h1234_0000, wmask: 8'h0C});
      resp_q.push_back('{rdata: 32'h0, err: 1'b0});
      send(1'b1, 32'h8000_0002, 32'h0000_1234, SZ_H, 1'b0, 3);
      wait_done("half_store");
      mem_q.push_back('{wen: 1'b1, addr: 32'h8000_0004, wdata: 32'h0000_AB00, wmask: 8'h02});
      resp_q.push_back('{rdata: 32'h0, err: 1'b0});
      send(1'b1, 32'h8000_0005, 32'h0000_00AB, SZ_B, 1'b0, 3);
      wait_done("byte_store");

      // Misaligned word, misaligned half and reserved size
      mem_word = 32'hA1B2_C3D4;
`ifdef LSU_ALIGN_CHECK_EN
      resp_q.push_back('{rdata: 32'h0, err: 1'b1});
      send(1'b0, 32'h8000_0001, 32'h0, SZ_W, 1'b0, 1);
      wait_done("misaligned_word");
      resp_q.push_back('{rdata: 32'h0, err: 1'b1});
      send(1'b0, 32'h8000_0003, 32'h0, SZ_H, 1'b1, 1);
      wait_done("misaligned_half");
      resp_q.push_back('{rdata: 32'h0, err: 1'b1});
      send(1'b1, 32'h8000_0000, 32'h5555_AAAA, 2'd3, 1'b0, 1);
      wait_done("reserved_size");
`else
      mem_q.push_back('{wen: 1'b0, addr: 32'h8000_0000, wdata: 32'h0, wmask: 8'h00});
      resp_q.push_back('{rdata: 32'h00A1_B2C3, err: 1'b0});
      send(1'b0, 32'h8000_0001, 32'h0, SZ_W, 1'b0, 3);
      wait_done("misaligned_word");
      mem_q.push_back('{wen: 1'b0, addr: 32'h8000_0000, wdata: 32'h0, wmask: 8'h00});
      resp_q.push_back('{rdata: 32'h0000_00A1, err: 1'b0});
      send(1'b0, 32'h8000_0003, 32'h0, SZ_H, 1'b1, 3);
      wait_done("misaligned_half");
      mem_q.push_back('{wen: 1'b1, addr: 32'h8000_0000, wdata: 32'h5555_AAAA, wmask: 8'h0F});
      resp_q.push_back('{rdata: 32'h0, err: 1'b0});
      send(1'b1, 32'h8000_0000, 32'h5555_AAAA, 2'd3, 1'b0, 3);
      wait_done("reserved_size");
`endif

      // Response backpressure with a competing request held on the core side
      mem_word = 32'h1122_3344;
      bus.resp_ready = 1'b0;
      mem_q.push_back('{wen: 1'b0, addr: 32'h8000_0010, wdata: 32'h0, wmask: 8'h00});
      resp_q.push_back('{rdata: 32'h1122_3344, err: 1'b0});
      send(1'b0, 32'h8000_0010, 32'h0, SZ_W, 1'b0, 3);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h8000_0020;
      repeat (5) begin
         @(negedge clk);
         chk("stall_resp_valid", {31'b0, bus.resp_valid}, 32'd1);
         chk("stall_resp_rdata", bus.resp_rdata, 32'h1122_3344);
         chk("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
         chk("stall_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      wait_done("backpressure");

      // Reset during WAIT drops the transaction
      mem_word = 32'h5566_7788;
      mem_q.push_back('{wen: 1'b0, addr: 32'h8000_0008, wdata: 32'h0, wmask: 8'h00});
      send(1'b0, 32'h8000_0008, 32'h0, SZ_W, 1'b0, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_idle_outputs("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check_idle_outputs("after_drop");

      chk("resp_q_empty", resp_q.size(), 32'd0);
      chk("mem_q_empty", mem_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
